// File: rtl/ecc_rf_pkg.sv
// Shared types and constants for the ECC register-file sequencer.
// Register map: key 0-7, X 8-15, Y 16-23, START 30, DONE 31.
package ecc_rf_pkg;
  localparam int WORDS = 8;

  localparam logic [4:0] KEY_BASE   = 5'd0;
  localparam logic [4:0] X_BASE     = 5'd8;
  localparam logic [4:0] Y_BASE     = 5'd16;
  localparam logic [4:0] START_ADDR = 5'd30;
  localparam logic [4:0] DONE_ADDR  = 5'd31;

  localparam logic [4:0] LOAD_LAST  = 5'(3 * WORDS - 1);
  localparam logic [4:0] STORE_LAST = 5'(2 * WORDS - 1);

  localparam logic [31:0] DONE_OK      = 32'h1;
  localparam logic [31:0] DONE_TIMEOUT = 32'h2;

  typedef enum logic [2:0] {
    IDLE, CLRDONE, LOAD, LAUNCH, WAIT, STORE, FLAG, CLEAR
  } state_e;

  function automatic logic [31:0] word_of(input logic [255:0] v, input logic [2:0] i);
    word_of = v[32*i +: 32];
  endfunction
endpackage

// File: rtl/ecc_rf_sequencer_if.sv
// Avalon-MM host port of the ECC register file: zero-latency when idle,
// held off with avl_waitrequest while the sequencer owns the register port.
interface ecc_rf_sequencer_if;
  logic        avl_read;
  logic        avl_write;
  logic [4:0]  avl_addr;
  logic [31:0] avl_writedata;
  logic [3:0]  avl_byte_en;
  logic [31:0] avl_readdata;
  logic        avl_waitrequest;

  modport master (
    output avl_read, avl_write, avl_addr, avl_writedata, avl_byte_en,
    input  avl_readdata, avl_waitrequest
  );

  modport slave (
    input  avl_read, avl_write, avl_addr, avl_writedata, avl_byte_en,
    output avl_readdata, avl_waitrequest
  );
endinterface

// File: rtl/operand_gather_256.sv
// Scatters 32-bit words (index 0-23) into key/X/Y 256-bit operand registers.
// One-cycle write latency; no backpressure, a word is taken whenever word_we is high.
module operand_gather_256
  import ecc_rf_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         word_we,
  input  logic [4:0]   word_idx,
  input  logic [31:0]  word_dat,
  output logic [255:0] key_q,
  output logic [255:0] px_q,
  output logic [255:0] py_q
);
  logic [255:0] key_d, px_d, py_d;

  always_comb begin
    key_d = key_q;
    px_d  = px_q;
    py_d  = py_q;
    if (word_we) begin
      // Bases are multiples of WORDS, so the low index bits select the slice
      if (word_idx < X_BASE)      key_d[32*word_idx[2:0] +: 32] = word_dat;
      else if (word_idx < Y_BASE) px_d[32*word_idx[2:0] +: 32]  = word_dat;
      else                        py_d[32*word_idx[2:0] +: 32]  = word_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
      px_q  <= '0;
      py_q  <= '0;
    end else begin
      key_q <= key_d;
      px_q  <= px_d;
      py_q  <= py_d;
    end
  end
endmodule

// File: rtl/ecc_rf_sequencer.sv
// Arbitrates the ECC regfile port and runs load/launch/store on START; START->DONE = 45 cycles + core time.
// Host is zero-latency in IDLE/WAIT, else stalled via avl_waitrequest; ECC_RF_TIMEOUT_EN adds a WAIT watchdog.
module ecc_rf_sequencer
  import ecc_rf_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
)
(
  input  logic               Clk,
  input  logic               Reset_n,
  ecc_rf_sequencer_if.slave  avl,
  output logic [4:0]         rf_addr,
  output logic               rf_load,
  output logic [31:0]        rf_write_data,
  output logic [3:0]         rf_byte_en,
  input  logic [31:0]        rf_data_out,
  output logic               core_start,
  output logic [255:0]       core_key,
  output logic [255:0]       core_px,
  output logic [255:0]       core_py,
  input  logic               core_done,
  input  logic [255:0]       core_rx,
  input  logic [255:0]       core_ry
);
  state_e       state_q, state_d;
  logic [4:0]   idx_q, idx_d;
  logic [255:0] rx_q, rx_d, ry_q, ry_d;
  logic         timed_out_q, timed_out_d;
  logic         core_start_q, core_start_d;
  logic         host_owns, start_hit;
`ifdef ECC_RF_TIMEOUT_EN
  logic [31:0]  wait_cnt_q, wait_cnt_d;
`endif

  assign host_owns  = (state_q == IDLE) || (state_q == WAIT);
  assign start_hit  = avl.avl_write && (avl.avl_addr == START_ADDR) &&
                      avl.avl_byte_en[0] && avl.avl_writedata[0];
  assign core_start = core_start_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rx_d         = rx_q;
    ry_d         = ry_q;
    timed_out_d  = timed_out_q;
    core_start_d = 1'b0;
`ifdef ECC_RF_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_hit) begin
          state_d     = CLRDONE;
          timed_out_d = 1'b0;
        end
      end
      CLRDONE: begin
        state_d = LOAD;
        idx_d   = '0;
      end
      LOAD: begin
        if (idx_q == LOAD_LAST) begin
          state_d      = LAUNCH;
          core_start_d = 1'b1;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      LAUNCH: begin
        state_d = WAIT;
`ifdef ECC_RF_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      WAIT: begin
        if (core_done) begin
          rx_d    = core_rx;
          ry_d    = core_ry;
          idx_d   = '0;
          state_d = STORE;
        end
`ifdef ECC_RF_TIMEOUT_EN
        else if (wait_cnt_q == TIMEOUT_CYCLES - 1) begin
          timed_out_d = 1'b1;
          state_d     = FLAG;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
`endif
      end
      STORE: begin
        if (idx_q == STORE_LAST) state_d = FLAG;
        else                     idx_d   = idx_q + 5'd1;
      end
      FLAG:    state_d = CLEAR;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    avl.avl_readdata    = rf_data_out;
    avl.avl_waitrequest = host_owns ? 1'b0 : (avl.avl_read | avl.avl_write);
    rf_addr       = '0;
    rf_load       = 1'b0;
    rf_write_data = '0;
    rf_byte_en    = 4'b0000;
    case (state_q)
      IDLE, WAIT: begin
        rf_addr       = avl.avl_addr;
        rf_load       = avl.avl_write;
        rf_write_data = avl.avl_writedata;
        rf_byte_en    = avl.avl_byte_en;
      end
      CLRDONE: begin
        rf_addr    = DONE_ADDR;
        rf_load    = 1'b1;
        rf_byte_en = 4'b1111;
      end
      LOAD: rf_addr = KEY_BASE + idx_q;
      STORE: begin
        // Indices 0-7 carry rx into X, 8-15 carry ry into Y
        rf_addr       = X_BASE + idx_q;
        rf_load       = 1'b1;
        rf_byte_en    = 4'b1111;
        rf_write_data = idx_q[3] ? word_of(ry_q, idx_q[2:0]) : word_of(rx_q, idx_q[2:0]);
      end
      FLAG: begin
        rf_addr       = DONE_ADDR;
        rf_load       = 1'b1;
        rf_byte_en    = 4'b1111;
        rf_write_data = timed_out_q ? DONE_TIMEOUT : DONE_OK;
      end
      CLEAR: begin
        rf_addr    = START_ADDR;
        rf_load    = 1'b1;
        rf_byte_en = 4'b1111;
      end
      default: ;
    endcase
  end

  operand_gather_256 u_gather (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .word_we  (state_q == LOAD),
    .word_idx (idx_q),
    .word_dat (rf_data_out),
    .key_q    (core_key),
    .px_q     (core_px),
    .py_q     (core_py)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      rx_q         <= '0;
      ry_q         <= '0;
      timed_out_q  <= 1'b0;
      core_start_q <= 1'b0;
`ifdef ECC_RF_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rx_q         <= rx_d;
      ry_q         <= ry_d;
      timed_out_q  <= timed_out_d;
      core_start_q <= core_start_d;
`ifdef ECC_RF_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_ecc_rf_sequencer.sv
// Bench for ecc_rf_sequencer: regfile and point-multiply core models, host read scoreboard.
`timescale 1ns/1ps
module tb_ecc_rf_sequencer;
  import ecc_rf_pkg::*;

`ifdef ECC_RF_TIMEOUT_EN
  localparam int CORE_DLY = 20;
  localparam int TO_CYC   = 50;
`else
  localparam int CORE_DLY = 100;
  localparam int TO_CYC   = 1000000;
`endif
  localparam int BOUND = 3000;

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  ecc_rf_sequencer_if avl();
  logic [4:0]   rf_addr;
  logic         rf_load;
  logic [31:0]  rf_write_data;
  logic [3:0]   rf_byte_en;
  logic [31:0]  rf_data_out;
  logic         core_start;
  logic [255:0] core_key, core_px, core_py;
  logic         core_done;
  logic [255:0] core_rx, core_ry;

  ecc_rf_sequencer #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .avl           (avl),
    .rf_addr       (rf_addr),
    .rf_load       (rf_load),
    .rf_write_data (rf_write_data),
    .rf_byte_en    (rf_byte_en),
    .rf_data_out   (rf_data_out),
    .core_start    (core_start),
    .core_key      (core_key),
    .core_px       (core_px),
    .core_py       (core_py),
    .core_done     (core_done),
    .core_rx       (core_rx),
    .core_ry       (core_ry)
  );

  // Register file model: byte-enabled synchronous write, combinational read
  logic [31:0] rf [32];
  assign rf_data_out = rf[rf_addr];
  always @(posedge Clk)
    if (rf_load)
      for (int b = 0; b < 4; b++)
        if (rf_byte_en[b]) rf[rf_addr][8*b +: 8] <= rf_write_data[8*b +: 8];

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int last_stall = 0;
  int n_start = 0;
  logic core_en = 1'b1;

  typedef struct packed {
    logic [255:0] key;
    logic [255:0] px;
    logic [255:0] py;
  } op_t;
  op_t         op_q[$];
  logic [31:0] rd_q[$];

  typedef struct packed {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;
  localparam int NV = 9;
  vec_t tbl[NV];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_bound(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got no response within %0d cycles, expected one", nm, BOUND);
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic host_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be,
                            output int wc);
    int n;
    n = 0;
    avl.avl_write = 1'b1; avl.avl_addr = a; avl.avl_writedata = d; avl.avl_byte_en = be;
    @(negedge Clk);
    while (avl.avl_waitrequest !== 1'b0 && n < BOUND) begin
      @(negedge Clk);
      n++;
    end
    if (n >= BOUND) fail_bound("host_write");
    last_stall = n;
    wc = cyc;
    @(posedge Clk);
    #1;
    avl.avl_write = 1'b0; avl.avl_byte_en = 4'h0;
  endtask

  task automatic host_read(input logic [4:0] a, input logic [31:0] exp, input string nm,
                           output int rc);
    int n;
    logic [31:0] e;
    n = 0;
    rd_q.push_back(exp);
    avl.avl_read = 1'b1; avl.avl_addr = a;
    @(negedge Clk);
    while (avl.avl_waitrequest !== 1'b0 && n < BOUND) begin
      @(negedge Clk);
      n++;
    end
    e = rd_q.pop_front();
    if (n >= BOUND) fail_bound(nm);
    else chk(nm, avl.avl_readdata, e);
    last_stall = n;
    rc = cyc;
    @(posedge Clk);
    #1;
    avl.avl_read = 1'b0;
  endtask

  task automatic wait_done(input logic [31:0] val, output int dc);
    int n;
    n = 0;
    @(negedge Clk);
    while (rf[DONE_ADDR] !== val && n < BOUND) begin
      @(negedge Clk);
      n++;
    end
    if (n >= BOUND) fail_bound("wait_done");
    dc = cyc;
    tick();
  endtask

  // Point-multiply core model: checks operands at launch, answers CORE_DLY WAIT cycles later
  initial begin
    op_t op;
    core_done = 1'b0;
    core_rx   = {32{8'hA5}};
    core_ry   = {32{8'h5A}};
    forever begin
      @(negedge Clk);
      if (core_start === 1'b1) begin
        n_start++;
        if (op_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL core_start: got an unexpected launch pulse, expected none");
        end else begin
          op = op_q.pop_front();
          chk("core_key", core_key, op.key);
          chk("core_px", core_px, op.px);
          chk("core_py", core_py, op.py);
        end
        if (core_en) begin
          repeat (CORE_DLY + 1) @(posedge Clk);
          #1 core_done = 1'b1;
          @(posedge Clk);
          #1 core_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by %0t, expected $finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tw, dc, rc, idle_stall;
    logic [255:0] k_exp, x_exp, y_exp, a5, s5a;
    avl.avl_read = 1'b0; avl.avl_write = 1'b0; avl.avl_addr = '0;
    avl.avl_writedata = '0; avl.avl_byte_en = '0;

    tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 4'b1111, 32'h0};
    tbl[1] = '{1'b0, 5'd5, 32'h0,        4'b0000, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 5'd6, 32'hFFFFFFFF, 4'b1111, 32'h0};
    tbl[3] = '{1'b1, 5'd6, 32'h12345678, 4'b0101, 32'h0};
    tbl[4] = '{1'b0, 5'd6, 32'h0,        4'b0000, 32'hFF34FF78};
    tbl[5] = '{1'b1, 5'd5, 32'h00000000, 4'b0000, 32'h0};
    tbl[6] = '{1'b0, 5'd5, 32'h0,        4'b0000, 32'hDEADBEEF};
    tbl[7] = '{1'b1, 5'd6, 32'hAABBCCDD, 4'b1000, 32'h0};
    tbl[8] = '{1'b0, 5'd6, 32'h0,        4'b0000, 32'hAA34FF78};

    a5  = {32{8'hA5}};
    s5a = {32{8'h5A}};
    for (int i = 0; i < 8; i++) begin
      k_exp[32*i +: 32] = 32'h00000001 + i;
      x_exp[32*i +: 32] = 32'h11111111 + i;
      y_exp[32*i +: 32] = 32'h22222222 + i;
    end

    // Reset state
    Reset_n = 1'b1;
    #1 Reset_n = 1'b0;
    repeat (3) tick();
    avl.avl_read = 1'b1;
    #1;
    chk("reset_waitrequest", avl.avl_waitrequest, 0);
    chk("reset_core_start", core_start, 0);
    chk("reset_rf_load", rf_load, 0);
    chk("reset_rf_byte_en", rf_byte_en, 4'b0000);
    chk("reset_core_key", core_key, 0);
    avl.avl_read = 1'b0;
    Reset_n = 1'b1;
    tick();

    // Zero-latency host accesses in IDLE
    idle_stall = 0;
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].wr) host_write(tbl[i].addr, tbl[i].data, tbl[i].be, tw);
      else           host_read(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d_read", i), tw);
      if (last_stall > idle_stall) idle_stall = last_stall;
    end
    chk("idle_stall_cycles", idle_stall, 0);

    // Full run with a busy-stall read of DONE during LOAD
    for (int i = 0; i < 8; i++) begin
      host_write(KEY_BASE + 5'(i), k_exp[32*i +: 32], 4'hF, tw);
      host_write(X_BASE + 5'(i), x_exp[32*i +: 32], 4'hF, tw);
      host_write(Y_BASE + 5'(i), y_exp[32*i +: 32], 4'hF, tw);
    end
    host_write(DONE_ADDR, 32'hFFFFFFFF, 4'hF, tw);
    op_q.push_back('{k_exp, x_exp, y_exp});
    host_write(START_ADDR, 32'h1, 4'hF, t0);
    repeat (4) tick();
    host_read(DONE_ADDR, 32'h0, "busy_read_done", rc);
    chk("busy_release_cycle", rc - t0, 27);
    wait_done(DONE_OK, dc);
    chk("done_latency", dc - t0, 45 + CORE_DLY);
    chk("starts_after_run1", n_start, 1);
    for (int i = 0; i < 16; i++)
      host_read(X_BASE + 5'(i), (i < 8) ? 32'hA5A5A5A5 : 32'h5A5A5A5A,
                $sformatf("result_reg%0d", 8 + i), tw);
    host_read(DONE_ADDR, DONE_OK, "run1_reg31", tw);
    host_read(START_ADDR, 32'h0, "run1_reg30", tw);

    // START during WAIT updates reg30 but does not relaunch
    op_q.push_back('{k_exp, a5, s5a});
    host_write(START_ADDR, 32'h1, 4'hF, t0);
    repeat (30) tick();
    host_write(START_ADDR, 32'h1, 4'hF, tw);
    chk("wait_write_stall", last_stall, 0);
    host_read(START_ADDR, 32'h1, "wait_reg30", tw);
    wait_done(DONE_OK, dc);
    repeat (30) tick();
    chk("starts_after_run2", n_start, 2);
    host_read(START_ADDR, 32'h0, "run2_reg30", tw);

`ifdef ECC_RF_TIMEOUT_EN
    // Watchdog: core never answers, results stay untouched
    core_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      x_exp[32*i +: 32] = 32'h33333333 + i;
      y_exp[32*i +: 32] = 32'h44444444 + i;
      host_write(X_BASE + 5'(i), x_exp[32*i +: 32], 4'hF, tw);
      host_write(Y_BASE + 5'(i), y_exp[32*i +: 32], 4'hF, tw);
    end
    op_q.push_back('{k_exp, x_exp, y_exp});
    host_write(START_ADDR, 32'h1, 4'hF, t0);
    wait_done(DONE_TIMEOUT, dc);
    chk("timeout_latency", dc - t0, 28 + TO_CYC);
    for (int i = 0; i < 8; i++) begin
      host_read(X_BASE + 5'(i), x_exp[32*i +: 32], $sformatf("to_x%0d", i), tw);
      host_read(Y_BASE + 5'(i), y_exp[32*i +: 32], $sformatf("to_y%0d", i), tw);
    end
    host_read(DONE_ADDR, DONE_TIMEOUT, "timeout_reg31", tw);
    host_read(START_ADDR, 32'h0, "timeout_reg30", tw);
    chk("timeout_idle_stall", last_stall, 0);
    core_en = 1'b1;
`endif

    // Asynchronous reset in the middle of LOAD
    tw = n_start;
    host_write(START_ADDR, 32'h1, 4'hF, t0);
    repeat (9) tick();
    avl.avl_read = 1'b1;
    avl.avl_addr = 5'd0;
    @(negedge Clk);
    chk("busy_before_reset", avl.avl_waitrequest, 1);
    #2 Reset_n = 1'b0;
    #1;
    chk("midreset_waitrequest", avl.avl_waitrequest, 0);
    chk("midreset_core_start", core_start, 0);
    chk("midreset_rf_load", rf_load, 0);
    chk("midreset_core_key", core_key, 0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    avl.avl_read = 1'b0;
    repeat (60) tick();
    chk("starts_after_reset", n_start, tw);
    host_read(DONE_ADDR, 32'h0, "reset_reg31", rc);
    host_read(START_ADDR, 32'h1, "reset_reg30", rc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
